// File: rtl/seq_alu.sv
// seq_alu: registered, handshaked ALU with an iterative shift-add multiplier.
//
// Handshake rules (both sides): a transfer happens at a rising CLK edge where
// valid and ready are both high. The producer holds A/B/Sel stable while
// In_Valid=1 and In_Ready=0. Out is held stable while Out_Valid=1 and
// Out_Ready=0. In_Ready and Out_Valid are decoded from registered state only,
// so there is no combinational path from Out_Ready to In_Ready.
//
// Ports:
//   CLK        clock, rising edge
//   RST        synchronous active-high reset
//   A, B       unsigned operands (Width bits)
//   Sel        opcode (3 bits)
//   In_Valid   operands/opcode valid
//   In_Ready   block can accept operands (IDLE)
//   Out        result (2*Width bits)
//   Out_Valid  Out holds a valid result (DONE)
//   Out_Ready  consumer accepts Out
//   Zero,Carry result flags, present only when SEQ_ALU_FLAGS_EN is defined
//   dbg_state  current FSM state (0=IDLE, 1=CALC, 2=DONE)
//
// Optional feature macro: SEQ_ALU_FLAGS_EN adds the registered Zero/Carry
// outputs, updated at the same edge as Out.

module seq_alu #(
  parameter int Width = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [Width-1:0]     A,
  input  logic [Width-1:0]     B,
  input  logic [2:0]           Sel,
  input  logic                 In_Valid,
  output logic                 In_Ready,
  output logic [2*Width-1:0]   Out,
  output logic                 Out_Valid,
  input  logic                 Out_Ready,
`ifdef SEQ_ALU_FLAGS_EN
  output logic                 Zero,
  output logic                 Carry,
`endif
  output logic [1:0]           dbg_state
);

  localparam int RW = 2 * Width;
  localparam int CW = $clog2(Width);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_INC = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_MAX = 3'b111;

  localparam logic [CW-1:0] LAST_STEP = CW'(Width - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [RW-1:0] acc_q;
  logic [RW-1:0] mcand_q;   // multiplicand, shifted left one place per step
  logic [Width-1:0] mplier_q; // multiplier, shifted right; bit 0 is the current step
  logic [RW-1:0] out_q;

  logic [RW-1:0] a_ext, b_ext;
  logic [RW-1:0] alu_res;
  logic [RW-1:0] acc_next;
  logic          last_step;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (In_Valid) state_d = (Sel == OP_MUL) ? S_CALC : S_DONE;
      S_CALC: if (last_step) state_d = S_DONE;
      S_DONE: if (Out_Ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode (state-only, so handshake outputs are glitch-free registers
  // decoded from state)
  // ---------------------------------------------------------------------------
  always_comb begin
    In_Ready  = (state_q == S_IDLE);
    Out_Valid = (state_q == S_DONE);
    Out       = out_q;
    dbg_state = state_q;
  end

  // ---------------------------------------------------------------------------
  // Single-cycle datapath for every opcode except MUL
  // ---------------------------------------------------------------------------
  always_comb begin
    a_ext = {{Width{1'b0}}, A};
    b_ext = {{Width{1'b0}}, B};
    case (Sel)
      OP_ADD:  alu_res = a_ext + b_ext;
      OP_AND:  alu_res = a_ext & b_ext;
      OP_INC:  alu_res = a_ext + RW'(1);
      OP_SUB:  alu_res = a_ext - b_ext;
      OP_OR:   alu_res = a_ext | b_ext;
      OP_XOR:  alu_res = a_ext ^ b_ext;
      OP_MAX:  alu_res = (A > B) ? a_ext : b_ext;
      default: alu_res = '0;  // MUL goes through the iterative path
    endcase
  end

  // One shift-add partial product per CALC cycle.
  always_comb begin
    acc_next  = acc_q + (mplier_q[0] ? mcand_q : '0);
    last_step = (cnt_q == LAST_STEP);
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      out_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (In_Valid) begin
            if (Sel == OP_MUL) begin
              cnt_q    <= '0;
              acc_q    <= '0;
              mcand_q  <= {{Width{1'b0}}, A};
              mplier_q <= B;
            end else begin
              out_q <= alu_res;
            end
          end
        end
        S_CALC: begin
          acc_q    <= acc_next;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (last_step) out_q <= acc_next;
        end
        default: ;  // DONE holds everything
      endcase
    end
  end

`ifdef SEQ_ALU_FLAGS_EN
  logic carry_res;

  always_comb begin
    case (Sel)
      OP_ADD, OP_INC: carry_res = alu_res[Width];
      OP_SUB:         carry_res = (A < B);
      default:        carry_res = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      Zero  <= 1'b0;
      Carry <= 1'b0;
    end else begin
      if (state_q == S_IDLE && In_Valid && Sel != OP_MUL) begin
        Zero  <= (alu_res == '0);
        Carry <= carry_res;
      end else if (state_q == S_CALC && last_step) begin
        Zero  <= (acc_next == '0);
        Carry <= (acc_next[RW-1:Width] != '0);
      end
    end
  end
`endif

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (Width=8). Expected results come from a
// plain-arithmetic reference model; back-to-back traffic uses an expected
// queue as scoreboard.

module tb_seq_alu;

  localparam int W  = 8;
  localparam int RW = 2 * W;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [W-1:0]  A = '0;
  logic [W-1:0]  B = '0;
  logic [2:0]    Sel = '0;
  logic          In_Valid = 1'b0;
  logic          In_Ready;
  logic [RW-1:0] Out;
  logic          Out_Valid;
  logic          Out_Ready = 1'b0;
  logic [1:0]    dbg_state;
`ifdef SEQ_ALU_FLAGS_EN
  logic          Zero;
  logic          Carry;
`endif

  always #5 CLK = ~CLK;

  seq_alu #(.Width(W)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .A         (A),
    .B         (B),
    .Sel       (Sel),
    .In_Valid  (In_Valid),
    .In_Ready  (In_Ready),
    .Out       (Out),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready),
`ifdef SEQ_ALU_FLAGS_EN
    .Zero      (Zero),
    .Carry     (Carry),
`endif
    .dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [RW-1:0] exp_q[$];

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic [RW-1:0] model_res(input int unsigned a, input int unsigned b,
                                              input int unsigned sel);
    int unsigned r;
    case (sel)
      0: r = a + b;
      1: r = a & b;
      2: r = a * b;
      3: r = a + 1;
      4: r = a - b;          // 32-bit wrap, low RW bits are the RW-bit result
      5: r = a | b;
      6: r = a ^ b;
      default: r = (a > b) ? a : b;
    endcase
    return RW'(r);
  endfunction

  function automatic logic model_carry(input int unsigned a, input int unsigned b,
                                       input int unsigned sel);
    int unsigned r;
    r = a + b;
    case (sel)
      0: return ((a + b) >> W) != 0;
      2: return ((a * b) >> W) != 0;
      3: return ((a + 1) >> W) != 0;
      4: return a < b;
      default: return (r != r);  // always 0
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
  endtask

  // Issues one operation and consumes its result; lat counts cycles from the
  // acceptance edge to the first sample point with Out_Valid=1.
  task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2:0] sel, output logic [RW-1:0] res,
                          output int lat, output logic z, output logic c);
    int guard;
    guard = 0;
    while (!In_Ready && guard < 100) begin
      tick();
      guard++;
    end
    A = a; B = b; Sel = sel; In_Valid = 1'b1;
    tick();
    In_Valid = 1'b0;
    lat = 1;
    while (!Out_Valid && lat < 100) begin
      tick();
      lat++;
    end
    n_checks++;
    if (!Out_Valid) begin
      n_fail++;
      $display("FAIL drive_op_timeout: Out_Valid=%0b after %0d cycles, required 1", Out_Valid, lat);
    end
    res = Out;
`ifdef SEQ_ALU_FLAGS_EN
    z = Zero;
    c = Carry;
`else
    z = 1'b0;
    c = 1'b0;
`endif
    Out_Ready = 1'b1;
    tick();
    Out_Ready = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    A = 8'hFF; B = 8'hFF; Sel = 3'b000; In_Valid = 1'b1; Out_Ready = 1'b1;
    do_reset();
    In_Valid = 1'b0; Out_Ready = 1'b0;
    n_checks++;
    if (In_Ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %0b, required 1", In_Ready);
    end
    n_checks++;
    if (Out_Valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %0b, required 0", Out_Valid);
    end
    n_checks++;
    if (Out !== '0) begin
      n_fail++; $display("FAIL reset_out: got %h, required 0", Out);
    end
`ifdef SEQ_ALU_FLAGS_EN
    n_checks++;
    if (Zero !== 1'b0 || Carry !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: got Z=%0b C=%0b, required 0 0", Zero, Carry);
    end
`endif
  endtask

  task automatic test_add();
    logic [RW-1:0] res; int lat; logic z, c;
    drive_op(8'd200, 8'd100, 3'b000, res, lat, z, c);
    n_checks++;
    if (res !== 16'd300) begin
      n_fail++; $display("FAIL add_result: got %0d, required 300", res);
    end
    n_checks++;
    if (lat != 1) begin
      n_fail++; $display("FAIL add_latency: got %0d, required 1", lat);
    end
`ifdef SEQ_ALU_FLAGS_EN
    n_checks++;
    if (c !== 1'b1 || z !== 1'b0) begin
      n_fail++; $display("FAIL add_flags: got Z=%0b C=%0b, required 0 1", z, c);
    end
`endif
  endtask

  task automatic test_mul();
    int ir_low, seen;
    logic [RW-1:0] res;
    A = 8'd255; B = 8'd255; Sel = 3'b010; In_Valid = 1'b1;
    tick();
    In_Valid = 1'b0; A = 8'd3; B = 8'd7;  // must not disturb the capture
    Out_Ready = 1'b1;
    ir_low = 0; seen = 0; res = '0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      if (In_Ready) break;
      ir_low++;
      if (Out_Valid && seen == 0) begin
        seen = cyc;
        res = Out;
`ifdef SEQ_ALU_FLAGS_EN
        n_checks++;
        if (Carry !== 1'b1 || Zero !== 1'b0) begin
          n_fail++; $display("FAIL mul_flags: got Z=%0b C=%0b, required 0 1", Zero, Carry);
        end
`endif
      end
      tick();
    end
    Out_Ready = 1'b0;
    n_checks++;
    if (res !== 16'hFE01) begin
      n_fail++; $display("FAIL mul_result: got %h, required fe01", res);
    end
    n_checks++;
    if (seen != W + 1) begin
      n_fail++; $display("FAIL mul_latency: got %0d, required %0d", seen, W + 1);
    end
    n_checks++;
    if (ir_low != W + 1) begin
      n_fail++; $display("FAIL mul_in_ready_low: got %0d cycles, required %0d", ir_low, W + 1);
    end
  endtask

  task automatic test_corners();
    logic [RW-1:0] res; int lat; logic z, c;
    drive_op(8'd3, 8'd5, 3'b100, res, lat, z, c);
    n_checks++;
    if (res !== 16'hFFFE) begin
      n_fail++; $display("FAIL sub_borrow: got %h, required fffe", res);
    end
`ifdef SEQ_ALU_FLAGS_EN
    n_checks++;
    if (c !== 1'b1) begin
      n_fail++; $display("FAIL sub_carry: got %0b, required 1", c);
    end
`endif
    drive_op(8'd255, 8'd0, 3'b011, res, lat, z, c);
    n_checks++;
    if (res !== 16'h0100) begin
      n_fail++; $display("FAIL inc_wrap: got %h, required 0100", res);
    end
`ifdef SEQ_ALU_FLAGS_EN
    n_checks++;
    if (c !== 1'b1) begin
      n_fail++; $display("FAIL inc_carry: got %0b, required 1", c);
    end
`endif
    drive_op(8'd7, 8'd9, 3'b111, res, lat, z, c);
    n_checks++;
    if (res !== 16'd9) begin
      n_fail++; $display("FAIL max: got %0d, required 9", res);
    end
`ifdef SEQ_ALU_FLAGS_EN
    n_checks++;
    if (c !== 1'b0) begin
      n_fail++; $display("FAIL max_carry: got %0b, required 0", c);
    end
`endif
  endtask

  // SimpleALU-style sweep A=i, B=20-i over every opcode, then random traffic.
  task automatic test_sweep_random();
    logic [RW-1:0] res; int lat; logic z, c;
    logic [W-1:0] a, b; logic [2:0] sel;
    for (int n = 0; n < 8 * 21 + 40; n++) begin
      if (n < 8 * 21) begin
        a = W'(n / 8); b = W'(20 - n / 8); sel = 3'(n % 8);
      end else begin
        a = W'($urandom_range(0, (1 << W) - 1));
        b = W'($urandom_range(0, (1 << W) - 1));
        sel = 3'($urandom_range(0, 7));
      end
      drive_op(a, b, sel, res, lat, z, c);
      n_checks++;
      if (res !== model_res(a, b, sel)) begin
        n_fail++;
        $display("FAIL op_result: sel=%0d a=%0d b=%0d got %h, required %h",
                 sel, a, b, res, model_res(a, b, sel));
      end
      n_checks++;
      if (lat != ((sel == 3'b010) ? W + 1 : 1)) begin
        n_fail++; $display("FAIL op_latency: sel=%0d got %0d", sel, lat);
      end
`ifdef SEQ_ALU_FLAGS_EN
      n_checks++;
      if (z !== (model_res(a, b, sel) == '0) || c !== model_carry(a, b, sel)) begin
        n_fail++;
        $display("FAIL op_flags: sel=%0d a=%0d b=%0d got Z=%0b C=%0b, required Z=%0b C=%0b",
                 sel, a, b, z, c, model_res(a, b, sel) == '0, model_carry(a, b, sel));
      end
`endif
    end
  endtask

  task automatic test_backpressure();
    logic [RW-1:0] exp;
    exp = model_res(8'hA5, 8'h3C, 3'b110);
    A = 8'hA5; B = 8'h3C; Sel = 3'b110; In_Valid = 1'b1;
    tick();
    // keep requesting a different op; it must be ignored while stalled
    A = 8'd1; B = 8'd2; Sel = 3'b000;
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (Out_Valid !== 1'b1 || Out !== exp || In_Ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold cyc%0d: got V=%0b Out=%h R=%0b, required V=1 Out=%h R=0",
                 k, Out_Valid, Out, In_Ready, exp);
      end
      tick();
    end
    In_Valid = 1'b0;
    Out_Ready = 1'b1;
    tick();
    Out_Ready = 1'b0;
    n_checks++;
    if (Out_Valid !== 1'b0 || In_Ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release: got V=%0b R=%0b, required V=0 R=1", Out_Valid, In_Ready);
    end
    tick();
    n_checks++;
    if (Out_Valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_no_extra: got V=%0b, required 0", Out_Valid);
    end
  endtask

  task automatic test_reset_mid_mul();
    logic [RW-1:0] res; int lat; logic z, c;
    int stale;
    A = 8'd200; B = 8'd201; Sel = 3'b010; In_Valid = 1'b1;
    tick();
    In_Valid = 1'b0;
    tick(); tick(); tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    n_checks++;
    if (Out_Valid !== 1'b0 || Out !== '0 || In_Ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_mul: got V=%0b Out=%h R=%0b, required V=0 Out=0 R=1",
               Out_Valid, Out, In_Ready);
    end
    stale = 0;
    for (int k = 0; k < 12; k++) begin
      if (Out_Valid) stale++;
      tick();
    end
    n_checks++;
    if (stale != 0) begin
      n_fail++; $display("FAIL rst_stale_result: got %0d valid cycles, required 0", stale);
    end
    drive_op(8'd1, 8'd1, 3'b000, res, lat, z, c);
    n_checks++;
    if (res !== 16'd2 || lat != 1) begin
      n_fail++; $display("FAIL rst_then_add: got %0d lat %0d, required 2 lat 1", res, lat);
    end
  endtask

  task automatic test_back_to_back();
    int sent, recv, accepts;
    logic [RW-1:0] exp;
    sent = 0; recv = 0; accepts = 0;
    exp_q.delete();
    Out_Ready = 1'b1;
    for (int cyc = 0; cyc < 400 && recv < 10; cyc++) begin
      if (Out_Valid) begin
        recv++;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        n_checks++;
        if (Out !== exp) begin
          n_fail++; $display("FAIL b2b_result #%0d: got %h, required %h", recv, Out, exp);
        end
      end
      if (In_Ready) begin
        if (sent < 10) begin
          A = W'($urandom_range(0, (1 << W) - 1));
          B = W'($urandom_range(0, (1 << W) - 1));
          Sel = 3'($urandom_range(0, 7));
          In_Valid = 1'b1;
          exp_q.push_back(model_res(A, B, Sel));
          sent++;
          accepts++;
        end else begin
          In_Valid = 1'b0;
        end
      end
      tick();
    end
    In_Valid = 1'b0;
    Out_Ready = 1'b0;
    n_checks++;
    if (recv != 10 || accepts != 10 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_count: got recv=%0d accepts=%0d left=%0d, required 10 10 0",
               recv, accepts, exp_q.size());
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_add();
    test_mul();
    test_corners();
    test_sweep_random();
    test_backpressure();
    test_reset_mid_mul();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
